fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of `imem` and downstream-feeding the decode stage. It owns the program counter and drives `imem`'s combinational read address. It captures the returned 16-bit instruction word together with its PC into a 2-entry fetch queue. It presents the queue head to decode with a valid/ready handshake and accepts PC redirects from the execute stage.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `IMEM_AW`, default 12: `imem` address width; PC arithmetic wraps modulo 2^IMEM_AW.
- `clk` input 1: clock, all state updates on posedge.
- `rst_n` input 1: reset, synchronous, active-low.
- `imem_pc` output 16: read address to `imem`; bits [15:IMEM_AW] always 0.
- `imem_op` input 16: instruction word from `imem`, valid combinationally in the same cycle.
- `id_valid` output 1: queue head valid.
- `id_op` output 16: head instruction; 16'h0 when empty.
- `id_pc` output 16: PC of the head instruction; 16'h0 when empty.
- `id_ready` input 1: decode accepts the head this cycle.
- `redirect_valid` input 1: execute-stage redirect request.
- `redirect_pc` input 16: redirect target.

## Operation
- State: `pc_q`, 2-entry FIFO of {pc, op}, `count` (0..2), FSM {S_RUN, S_HALT}.
- `imem_pc = pc_q` masked to IMEM_AW bits.
- `deq = id_valid & id_ready`.
- `enq = (state == S_RUN) & (count < 2 | deq) & !redirect_valid`.
- On `enq`:
  - push {pc_q, imem_op};
  - `pc_q <= next_pc`, where default `next_pc = (pc_q + 1) mod 2^IMEM_AW`.
- On `deq`: pop the head. Simultaneous enq and deq at count==2 leaves count at 2, with FIFO order preserved.
- Redirect has priority over all other events:
  - `count <= 0` and the FIFO is cleared, including the head presented that cycle; decode must not treat that head as accepted.
  - `pc_q <= redirect_pc` masked to IMEM_AW bits.
  - `state <= S_RUN`.
- S_HALT:
  - Only reachable with FETCH_PREDECODE_EN.
  - No enqueues occur; the queue still drains through `deq`.
  - Exits only on redirect or reset.
- Reset, including mid-operation:
  - `pc_q = RESET_PC`, `count = 0`, `state = S_RUN`.
  - Outputs: `id_valid = 0`, `id_op = 0`, `id_pc = 0`, `imem_pc = RESET_PC`.
  - No enqueue occurs during reset cycles, since `imem` is being initialised.

## Timing
- Fetch latency: the instruction at `pc_q` is enqueued at the edge ending cycle t and is visible on `id_*` in cycle t+1.
- First `id_valid` appears in the first cycle after the first edge with `rst_n` high.
- Steady state with `id_ready = 1` is 1 instruction per cycle with no bubbles.
- Redirect costs 1 bubble:
  - In the cycle after the redirect, `id_valid = 0` and `imem_pc = target`.
  - The target instruction appears on `id_*` the cycle after that.
- Backpressure: `id_op`/`id_pc` are held stable while `id_valid & !id_ready`.
- `pc_q` holds whenever no enqueue occurs.

## Configuration
- `FETCH_PREDECODE_EN` defined:
  - When the enqueued `imem_op[15:11] == OP_JMP` (opcode value from def.h), `next_pc = pc_q + 1 + sext(imem_op[10:0])`, wrapped to IMEM_AW bits. This gives no redirect bubble for unconditional jumps.
  - If that target equals `pc_q` (self-jump, e.g. offset 11'h7FF), the jump is still enqueued, `pc_q` holds, and `state <= S_HALT`.
- Undefined:
  - `next_pc` is always `pc_q + 1`; jumps resolve only via redirect.
  - S_HALT is unreachable, and the predecode logic is absent from the netlist.

## Test plan
- Sequential fetch: reset, then `id_ready = 1` → `id_pc` 0,1,2,3 on consecutive cycles starting 1 cycle after reset release, with `id_op == imem[id_pc]`.
- Backpressure: `id_ready = 0` for 5 cycles after reset → count saturates at 2, `imem_pc` holds at 2, `id_pc` stays 0. Releasing `id_ready` yields 0,1,2,3 with no loss or duplication.
- Redirect while full: count=2, `redirect_valid = 1`, `redirect_pc = 16'h0010`, `id_ready = 1` → next cycle `id_valid = 0` and `imem_pc = 16'h0010`; the cycle after, `id_pc = 16'h0010`.
- Wrap: redirect to 16'h0FFF → `id_pc` sequence 0x0FFF, 0x0000, 0x0001.
- Predecode:
  - JMP +3 at PC 8, macro on → `id_pc` 8, 12, 13.
  - JMP 11'h7FF at PC 4 → PC 4 is enqueued, `imem_pc` stays 4, and no further `id_valid` appears after the drain. Redirect to 0 resumes at 0.
  - Macro off → same program yields 4, 5, 6.
- Reset mid-operation: count=2, `rst_n = 0` for 1 cycle → `id_valid = 0`, `id_op = 0`, `imem_pc = RESET_PC`; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem combinationally and queues {pc, op} pairs for decode.
// Optional macro FETCH_PREDECODE_EN adds zero-bubble handling of unconditional jumps, plus a halt on self-jumps.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          IMEM_AW  = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_pc,
    input  logic [15:0] imem_op,
    output logic        id_valid,
    output logic [15:0] id_op,
    output logic [15:0] id_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc
);
    localparam logic [15:0] PC_MASK = 16'((32'd1 << IMEM_AW) - 32'd1);

    typedef enum logic {S_RUN, S_HALT} state_t;
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] op;
    } entry_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    entry_t      ent0_q, ent0_d, ent1_q, ent1_d;
    entry_t      new_ent;
    logic        enq, deq, halt_req;
    logic [15:0] next_pc;

    // Outputs are forced idle while reset is asserted, so decode never sees stale entries.
    assign id_valid = rst_n & (count_q != 2'd0);
    assign id_op    = id_valid ? ent0_q.op : 16'h0;
    assign id_pc    = id_valid ? ent0_q.pc : 16'h0;
    assign imem_pc  = rst_n ? pc_q : (RESET_PC & PC_MASK);

    assign deq     = id_valid & id_ready;
    assign enq     = rst_n & (state_q == S_RUN) & ((count_q != 2'd2) | deq) & !redirect_valid;
    assign new_ent = '{pc: pc_q, op: imem_op};

`ifdef FETCH_PREDECODE_EN
    localparam logic [4:0] OP_JMP = 5'b11110;  // opcode value from def.h
    logic [15:0] jmp_tgt;

    always_comb begin
        jmp_tgt  = (pc_q + 16'd1 + {{5{imem_op[10]}}, imem_op[10:0]}) & PC_MASK;
        next_pc  = (pc_q + 16'd1) & PC_MASK;
        halt_req = 1'b0;
        if (imem_op[15:11] == OP_JMP) begin
            next_pc  = jmp_tgt;
            halt_req = (jmp_tgt == pc_q);
        end
    end
`else
    assign next_pc  = (pc_q + 16'd1) & PC_MASK;
    assign halt_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        if (redirect_valid) begin
            // Flush wins over any same-cycle dequeue; the presented head is dropped.
            count_d = 2'd0;
            pc_d    = redirect_pc & PC_MASK;
            state_d = S_RUN;
        end else begin
            if (enq) begin
                pc_d = next_pc;
                if (halt_req) state_d = S_HALT;
            end
            case ({enq, deq})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = new_ent;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = new_ent;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = new_ent;
                    else                 ent1_d = new_ent;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_RUN;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC & PC_MASK;
            count_q <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed tests with a scoreboard of expected {pc, op} handshakes plus cycle checks.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] imem_pc, imem_op, id_op, id_pc, redirect_pc;
    logic        id_valid, id_ready, redirect_valid;

    logic [15:0] mem [0:4095];
    assign imem_op = mem[imem_pc[11:0]];

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_op(imem_op),
        .id_valid(id_valid), .id_op(id_op), .id_pc(id_pc), .id_ready(id_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] op;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push_exp(input logic [15:0] pc, input logic [15:0] op);
        exp_t e;
        e.pc = pc;
        e.op = op;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted head (not cancelled by a redirect) must match the next expected entry.
    always @(negedge clk) begin
        if (mon_en && rst_n && id_valid && id_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_accept: got pc %h op %h expected none", id_pc, id_op);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", id_pc, e.pc);
                chk("sb_op", id_op, e.op);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left expected 0", exp_q.size());
            exp_q.delete();
        end
        mon_en = 1'b0;
    endtask

    task automatic redirect_to(input logic [15:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        tick();
        redirect_valid = 1'b0;
        chk("redir_bubble_valid", {15'd0, id_valid}, 16'd0);
        chk("redir_imem_pc", imem_pc, tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h5000 | 16'(i);
        rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0;

        // Reset state and sequential fetch
        tick(); tick();
        chk("rst_valid", {15'd0, id_valid}, 16'd0);
        chk("rst_op", id_op, 16'h0);
        chk("rst_pc", id_pc, 16'h0);
        chk("rst_imem_pc", imem_pc, 16'h0);
        for (int i = 0; i < 4; i++) push_exp(16'(i), 16'h5000 | 16'(i));
        mon_en = 1'b1;
        rst_n  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("seq_valid", {15'd0, id_valid}, 16'd1);
            chk("seq_pc", id_pc, 16'(i));
        end
        wait_drain();

        // Backpressure after reset
        rst_n = 1'b0; id_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_imem_pc", imem_pc, 16'h2);
        chk("bp_id_pc", id_pc, 16'h0);
        chk("bp_op", id_op, 16'h5000);
        for (int i = 0; i < 4; i++) push_exp(16'(i), 16'h5000 | 16'(i));
        mon_en = 1'b1;
        id_ready = 1'b1;
        wait_drain();

        // Redirect while full
        id_ready = 1'b0;
        tick(); tick(); tick();
        chk("full_valid", {15'd0, id_valid}, 16'd1);
        id_ready = 1'b1;
        push_exp(16'h0010, 16'h5010);
        push_exp(16'h0011, 16'h5011);
        mon_en = 1'b1;
        redirect_to(16'h0010);
        tick();
        chk("redir_target_pc", id_pc, 16'h0010);
        wait_drain();

        // Wrap at the top of the address space
        push_exp(16'h0FFF, 16'h5FFF);
        push_exp(16'h0000, 16'h5000);
        push_exp(16'h0001, 16'h5001);
        mon_en = 1'b1;
        redirect_to(16'h0FFF);
        tick(); chk("wrap_pc0", id_pc, 16'h0FFF);
        tick(); chk("wrap_pc1", id_pc, 16'h0000);
        tick(); chk("wrap_pc2", id_pc, 16'h0001);
        wait_drain();

        // Forward jump at PC 8
        mem[8] = 16'hF003;
        push_exp(16'h0008, 16'hF003);
`ifdef FETCH_PREDECODE_EN
        push_exp(16'h000C, 16'h500C);
        push_exp(16'h000D, 16'h500D);
`else
        push_exp(16'h0009, 16'h5009);
        push_exp(16'h000A, 16'h500A);
`endif
        mon_en = 1'b1;
        redirect_to(16'h0008);
        wait_drain();
        mem[8] = 16'h5008;

        // Self-jump at PC 4
        mem[4] = 16'hF7FF;
        push_exp(16'h0004, 16'hF7FF);
`ifdef FETCH_PREDECODE_EN
        mon_en = 1'b1;
        redirect_to(16'h0004);
        wait_drain();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_valid", {15'd0, id_valid}, 16'd0);
            chk("halt_imem_pc", imem_pc, 16'h0004);
        end
        mem[4] = 16'h5004;
        push_exp(16'h0000, 16'h5000);
        push_exp(16'h0001, 16'h5001);
        mon_en = 1'b1;
        redirect_to(16'h0000);
        wait_drain();
`else
        push_exp(16'h0005, 16'h5005);
        push_exp(16'h0006, 16'h5006);
        mon_en = 1'b1;
        redirect_to(16'h0004);
        wait_drain();
        mem[4] = 16'h5004;
`endif

        // Reset mid-operation with a full queue
        id_ready = 1'b0;
        tick(); tick(); tick();
        chk("mid_full_valid", {15'd0, id_valid}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {15'd0, id_valid}, 16'd0);
        chk("mid_rst_op", id_op, 16'h0);
        chk("mid_rst_imem_pc", imem_pc, 16'h0);
        tick();
        chk("post_rst_valid", {15'd0, id_valid}, 16'd0);
        chk("post_rst_imem_pc", imem_pc, 16'h0);
        push_exp(16'h0000, 16'h5000);
        push_exp(16'h0001, 16'h5001);
        mon_en   = 1'b1;
        id_ready = 1'b1;
        rst_n    = 1'b1;
        tick();
        chk("restart_pc", id_pc, 16'h0000);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
